// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants: PC width/increment and the sequencer state encoding.
package cpu_pkg;

  localparam int unsigned PC_W = 32;
  localparam logic [PC_W-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_HALTED  = 2'd2,
    ST_ILLEGAL = 2'd3
  } pc_state_e;

  // Redirects are only honoured while the front end is actively sequencing.
  function automatic logic accepts_redirect(input pc_state_e s);
    return (s == ST_RUN) || (s == ST_FLUSH);
  endfunction

endpackage

// File: rtl/pc_target_gen.sv
// Combinational target generation: sequential PC, branch/jump redirect target, alignment check.
module pc_target_gen
  import cpu_pkg::*;
(
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] branch_pc4,
  input  logic [PC_W-1:0] branch_imm,
  input  logic [25:0]     jump_index,
  input  logic            branch_sel,
  output logic [PC_W-1:0] pc_plus4,
  output logic [PC_W-1:0] target,
  output logic            target_misaligned
);

  logic [PC_W-1:0] branch_target;
  logic [PC_W-1:0] jump_target;

  always_comb begin
    pc_plus4      = pc + PC_INC;
    branch_target = branch_pc4 + (branch_imm << 2);
    jump_target   = {pc_plus4[31:28], jump_index, 2'b00};
    // Branch wins whenever it is requested; the jump target is only a fallback.
    target            = branch_sel ? branch_target : jump_target;
    target_misaligned = |target[1:0];
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: increment, stall, branch/jump redirect with flush bubbles, halt/resume.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_req,
  input  logic [31:0] branch_pc4,
  input  logic [31:0] branch_imm,
  input  logic        jump_req,
  input  logic [25:0] jump_index,
  input  logic        halt,
  input  logic        resume,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        flush,
  output logic        align_err,
  output logic [1:0]  state
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  pc_state_e       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            align_q, align_d;

  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] target;
  logic            target_misaligned;
  logic            redirect;

  pc_target_gen u_target_gen (
    .pc                (pc_q),
    .branch_pc4        (branch_pc4),
    .branch_imm        (branch_imm),
    .jump_index        (jump_index),
    .branch_sel        (branch_req),
    .pc_plus4          (pc_plus4),
    .target            (target),
    .target_misaligned (target_misaligned)
  );

  assign redirect = (branch_req | jump_req) & accepts_redirect(state_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= 3'd0;
      align_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      align_q <= align_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    align_d = align_q;

    if (redirect) begin
      // A redirect in FLUSH restarts the bubble count just like one in RUN.
      state_d = ST_FLUSH;
      pc_d    = target;
      cnt_d   = FLUSH_LOAD;
      align_d = align_q | target_misaligned;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (halt) begin
            state_d = ST_HALTED;
          end else if (!stall) begin
            pc_d = pc_plus4;
          end
        end
        ST_FLUSH: begin
          // Bubbles drain regardless of stall; halt waits until RUN.
          cnt_d = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) begin
            state_d = ST_RUN;
          end
        end
        ST_HALTED: begin
          if (resume) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  assign pc        = pc_q;
  assign pc_valid  = (state_q == ST_RUN);
  assign flush     = (state_q == ST_FLUSH);
  assign align_err = align_q;
  assign state     = state_q;

endmodule
